slave_select_fsm: RTL and testbench
===================================

# slave_select_fsm

Parametrised, registered successor to the SoC's plain 3-to-8 select decoder. It turns a binary slave index into a one-hot select that is held for the whole transfer. Requests are accepted through a grant handshake and closed by a slave completion strobe. Out-of-range indices and, optionally, hung slaves produce an error response. It sits between the peripheral-bus master port and the peripheral slave enables.

## Interface
Parameters:
- SEL_W, 3, width of the slave index; legal range 1..6
- N_SLV, 8, number of slaves; legal range 1..2**SEL_W; indices N_SLV..2**SEL_W-1 are unmapped
- TIMEOUT, 255, maximum ACTIVE cycles before abort; only used with SLV_SEL_TIMEOUT_EN; legal range 2..65535

Ports:
- clk_i  in  1  clock; all state updates on the rising edge
- rst_ni  in  1  reset; asynchronous, active-low
- req_i  in  1  master request; qualified by gnt_o
- addr_i  in  SEL_W  slave index, sampled on acceptance
- gnt_o  out  1  high exactly when the state is IDLE
- select_o  out  N_SLV  one-hot slave select, registered
- busy_o  out  1  high when the state is not IDLE
- done_i  in  1  slave completion strobe
- rsp_valid_o  out  1  one-cycle response pulse
- rsp_err_o  out  1  error flag; meaningful only when rsp_valid_o is high, otherwise 0

## Operation
- States:
  - IDLE: reset state.
  - ACTIVE: a slave is selected and the block waits for completion.
  - RESP: the response cycle.
- IDLE:
  - gnt_o=1, select_o=0.
  - Acceptance is req_i && gnt_o at a rising edge; addr_i is latched into idx_q.
  - If addr_i < N_SLV: go to ACTIVE and set select_o[addr_i]=1.
  - If addr_i >= N_SLV: go to RESP with err_q=1. No select bit is ever asserted.
- ACTIVE:
  - select_o holds one-hot(idx_q), gnt_o=0.
  - done_i=1 at an edge: go to RESP with err_q=0.
- RESP:
  - rsp_valid_o=1 for exactly one cycle; rsp_err_o=err_q; select_o=0.
  - Go to IDLE unconditionally.
- done_i is ignored in IDLE and RESP. A stray strobe produces no response.
- req_i while gnt_o=0 is ignored. The master must hold req_i and addr_i until granted.
- Index compare is unsigned over the full SEL_W bits. When N_SLV=2**SEL_W, no index is unmapped.
- Reset:
  - All registers clear asynchronously: state=IDLE, select_o=0, rsp_valid_o=0, rsp_err_o=0, busy_o=0, gnt_o=1.
  - Reset during ACTIVE drops the select immediately and emits no response.

## Timing
- Accept edge T: select_o is valid from T+1 (one cycle of latency; no combinational path from addr_i to select_o).
- done_i sampled high at edge D (D >= T+1): select_o falls and rsp_valid_o rises at D+1; gnt_o returns at D+2.
- done_i already high in the first ACTIVE cycle is accepted, giving a minimum ACTIVE length of 1 cycle.
- Unmapped index accepted at T: rsp_valid_o=1 and rsp_err_o=1 during T+1; gnt_o=1 again at T+2.
- Back-to-back: a legal transfer occupies at least 3 cycles from grant to the next grant.
- gnt_o and busy_o are decoded from the state register only. They have no combinational dependence on req_i.

## Configuration
- Macro: SLV_SEL_TIMEOUT_EN.
- Defined:
  - A cycle counter of width clog2(TIMEOUT+1) clears on entry to ACTIVE and increments each ACTIVE cycle with done_i=0.
  - When the counter equals TIMEOUT-1 and done_i=0, the next edge goes to RESP with err_q=1 and drops the select. The ACTIVE phase therefore lasts exactly TIMEOUT cycles.
  - If done_i=1 in the same cycle the timeout would fire, done wins and rsp_err_o=0.
- Undefined: no counter exists, and ACTIVE waits for done_i indefinitely. The TIMEOUT parameter is unused.

## Test plan
- Reset with defaults: during and after rst_ni low, select_o=8'h00, gnt_o=1, busy_o=0, rsp_valid_o=0.
- Legal transfer: req_i=1, addr_i=3'd5, done_i raised 4 cycles after grant. Required: select_o=8'h20 from T+1 to D; one rsp_valid_o pulse with rsp_err_o=0 at D+1; gnt_o=1 at D+2.
- Unmapped index with N_SLV=5, SEL_W=3, addr_i=3'd6. Required: select_o stays 5'b0; rsp_valid_o=1 and rsp_err_o=1 at T+1; exactly one pulse.
- Stray and early strobes: done_i pulsed in IDLE gives no response. done_i=1 in the first ACTIVE cycle with addr_i=0 gives select_o=8'h01 for one cycle, then a response.
- Mid-transfer reset: rst_ni asserted asynchronously with select_o=8'h04 active. Required: select_o=0 before the next edge, no rsp_valid_o, clean transfer afterwards.
- With SLV_SEL_TIMEOUT_EN, TIMEOUT=4 and done_i held 0:
  - select_o is high for exactly 4 cycles, then rsp_valid_o=1 and rsp_err_o=1.
  - Repeated run with done_i=1 in the 4th cycle: rsp_err_o=0.

Source files
------------

// File: rtl/slave_select_if.sv
// slave_select_if: master-port request/grant, one-hot slave select and response signals
// grouped for slave_select_fsm.
interface slave_select_if #(
    parameter int SEL_W = 3,
    parameter int N_SLV = 8
);
    logic             req_i;
    logic [SEL_W-1:0] addr_i;
    logic             gnt_o;
    logic [N_SLV-1:0] select_o;
    logic             busy_o;
    logic             done_i;
    logic             rsp_valid_o;
    logic             rsp_err_o;

    modport slave (
        input  req_i, addr_i, done_i,
        output gnt_o, select_o, busy_o, rsp_valid_o, rsp_err_o
    );

    modport master (
        output req_i, addr_i, done_i,
        input  gnt_o, select_o, busy_o, rsp_valid_o, rsp_err_o
    );
endinterface

// File: rtl/slave_select_fsm.sv
// slave_select_fsm: registered one-hot slave select held for a whole transfer, with error response
// for unmapped indices; define SLV_SEL_TIMEOUT_EN to also abort transfers that hang in ACTIVE.
module slave_select_fsm #(
    parameter int SEL_W   = 3,
    parameter int N_SLV   = 8,
    parameter int TIMEOUT = 255
) (
    input logic          clk_i,
    input logic          rst_ni,
    slave_select_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACTIVE, RESP} state_t;

    state_t           state_q, state_d;
    logic             err_q, err_d;
    logic [N_SLV-1:0] sel_q, sel_d, hit;
    logic             mapped, expire;

    if (SEL_W < 1 || SEL_W > 6 || N_SLV < 1 || N_SLV > (1 << SEL_W) || TIMEOUT < 2 || TIMEOUT > 65535)
    begin : g_bad_params
        $error("slave_select_fsm: parameter out of range");
    end

    for (genvar i = 0; i < N_SLV; i++) begin : g_hit
        assign hit[i] = bus.addr_i == SEL_W'(i);
    end

    // One extra bit so that N_SLV == 2**SEL_W compares correctly.
    assign mapped = {1'b0, bus.addr_i} < (SEL_W + 1)'(N_SLV);

`ifdef SLV_SEL_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q;
    assign expire = state_q == ACTIVE && !bus.done_i && cnt_q == CNT_W'(TIMEOUT - 1);
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else if (state_q != ACTIVE) cnt_q <= '0;
        else if (!bus.done_i) cnt_q <= cnt_q + CNT_W'(1);
    end
`else
    assign expire = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            err_q   <= 1'b0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            sel_q   <= sel_d;
        end
    end

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        sel_d   = sel_q;
        if (state_q == IDLE && bus.req_i) begin
            state_d = mapped ? ACTIVE : RESP;
            err_d   = !mapped;
            sel_d   = hit;
        end else if (state_q == ACTIVE && (bus.done_i || expire)) begin
            state_d = RESP;
            err_d   = !bus.done_i;
            sel_d   = '0;
        end else if (state_q == RESP) begin
            state_d = IDLE;
            err_d   = 1'b0;
        end
    end

    assign bus.gnt_o       = state_q == IDLE;
    assign bus.busy_o      = state_q != IDLE;
    assign bus.select_o    = sel_q;
    assign bus.rsp_valid_o = state_q == RESP;
    assign bus.rsp_err_o   = state_q == RESP && err_q;
endmodule

// File: tb/tb_slave_select_fsm.sv
// tb_slave_select_fsm: directed and random transfers on an 8-slave and a 5-slave instance,
// checked against a transaction-level expectation; honours SLV_SEL_TIMEOUT_EN with TIMEOUT=4.
module tb_slave_select_fsm;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req = 1'b0;
    logic [2:0] addr = '0;
    logic done = 1'b0;
    int dut = 0;
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    slave_select_if #(.SEL_W(3), .N_SLV(8)) bus_a ();
    slave_select_if #(.SEL_W(3), .N_SLV(5)) bus_b ();

    assign bus_a.req_i  = req && dut == 0;
    assign bus_a.addr_i = addr;
    assign bus_a.done_i = done && dut == 0;
    assign bus_b.req_i  = req && dut == 1;
    assign bus_b.addr_i = addr;
    assign bus_b.done_i = done && dut == 1;

    slave_select_fsm #(.SEL_W(3), .N_SLV(8), .TIMEOUT(TO)) u_a (.clk_i(clk), .rst_ni(rst_n), .bus(bus_a));
    slave_select_fsm #(.SEL_W(3), .N_SLV(5), .TIMEOUT(TO)) u_b (.clk_i(clk), .rst_ni(rst_n), .bus(bus_b));

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [7:0] es, input logic eg, input logic ev, input logic ee);
        check({tag, ".select"}, dut == 1 ? {3'b000, bus_b.select_o} : bus_a.select_o, es);
        check({tag, ".gnt"}, {7'd0, dut == 1 ? bus_b.gnt_o : bus_a.gnt_o}, {7'd0, eg});
        check({tag, ".busy"}, {7'd0, dut == 1 ? bus_b.busy_o : bus_a.busy_o}, {7'd0, !eg});
        check({tag, ".rsp_valid"}, {7'd0, dut == 1 ? bus_b.rsp_valid_o : bus_a.rsp_valid_o}, {7'd0, ev});
        check({tag, ".rsp_err"}, {7'd0, dut == 1 ? bus_b.rsp_err_o : bus_a.rsp_err_o}, {7'd0, ee});
    endtask

    // One transfer: done is presented in the k-th ACTIVE cycle (k beyond the timeout means never).
    task automatic transfer(input int d, input int a, input int k);
        int n, act;
        logic err;
        logic [7:0] exp_sel;
        n = d == 1 ? 5 : 8;
        dut = d;
        check_outputs("idle", 8'h00, 1'b1, 1'b0, 1'b0);
        req = 1'b1;
        addr = 3'(a);
        @(posedge clk);
        #1;
        req = 1'b0;
        addr = 3'($urandom);
        if (a < n) begin
            exp_sel = 8'(1 << a);
            act = k;
            err = 1'b0;
`ifdef SLV_SEL_TIMEOUT_EN
            if (k > TO) begin
                act = TO;
                err = 1'b1;
            end
`endif
            for (int j = 1; j <= act; j++) begin
                check_outputs("active", exp_sel, 1'b0, 1'b0, 1'b0);
                done = j == k;
                addr = 3'($urandom);
                @(posedge clk);
                #1;
            end
            done = 1'b0;
            check_outputs("resp", 8'h00, 1'b0, 1'b1, err);
        end else begin
            check_outputs("resp_unmapped", 8'h00, 1'b0, 1'b1, 1'b1);
        end
        @(posedge clk);
        #1;
        check_outputs("regrant", 8'h00, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic idle_cycles(input int c);
        for (int j = 0; j < c; j++) begin
            done = 1'($urandom);
            addr = 3'($urandom);
            @(posedge clk);
            #1;
            check_outputs("stray", 8'h00, 1'b1, 1'b0, 1'b0);
        end
        done = 1'b0;
    endtask

    initial begin
        #12;
        check_outputs("in_reset", 8'h00, 1'b1, 1'b0, 1'b0);
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_outputs("after_reset", 8'h00, 1'b1, 1'b0, 1'b0);
        transfer(0, 5, 4);
        transfer(1, 6, 2);
        idle_cycles(4);
        transfer(0, 0, 1);
        transfer(1, 4, 2);
        transfer(0, 7, 3);
        dut = 0;
        req = 1'b1;
        addr = 3'd2;
        @(posedge clk);
        #1;
        req = 1'b0;
        check_outputs("pre_reset", 8'h04, 1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check_outputs("async_reset", 8'h00, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_outputs("held_reset", 8'h00, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        transfer(0, 2, 2);
`ifdef SLV_SEL_TIMEOUT_EN
        transfer(0, 3, 100);
        transfer(0, 3, TO);
        transfer(1, 1, 100);
`endif
        for (int i = 0; i < 40; i++) begin
            transfer(int'($urandom_range(1)), int'($urandom_range(7)), int'($urandom_range(6, 1)));
            idle_cycles(int'($urandom_range(2)));
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
